// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch / issue / resolve control FSM that steers the 16-bit PC
//            register and the instruction-memory fetch handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [15:0] IRQ_VECTOR    = 16'h0004,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] pc_value,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic        instr_valid,
    output logic [15:0] instr,
    input  logic        instr_ready,
    input  logic        exec_done,
    input  logic        exec_branch,
    input  logic [15:0] exec_offset,
    input  logic        exec_jump,
    input  logic [15:0] exec_target,
    input  logic        exec_halt,
    input  logic        irq,
    output logic        irq_ack,
    output logic [15:0] epc,
    output logic        pc_enable,
    output logic        pc_increment,
    output logic        pc_load,
    output logic [15:0] pc_offset,
    output logic [15:0] pc_in,
    output logic        halted,
    output logic        fetch_error
);

    localparam int             CW         = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CW-1:0]  c_TMO_LAST = CW'(FETCH_TIMEOUT - 1);
    localparam logic [CW-1:0]  c_CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_RESOLVE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_tmo_cnt;
    logic [15:0]   r_instr;
    logic [15:0]   r_epc;
    logic          r_fetch_error;

    logic          w_resolve;
    logic          w_take_irq;
    logic          w_seq;
    logic [15:0]   w_next_pc;

    // Flow target ignoring the interrupt; it becomes the return PC on entry.
    always_comb begin
        w_next_pc = pc_value + 16'd1;
        if (exec_jump) begin
            w_next_pc = exec_target;
        end else if (exec_branch) begin
            w_next_pc = pc_value + exec_offset;
        end
    end

    assign w_resolve  = (r_state == S_RESOLVE) && exec_done;
    assign w_take_irq = w_resolve && !exec_halt && irq;
    assign w_seq      = !irq && !exec_jump && !exec_branch;

    assign imem_req     = (r_state == S_FETCH);
    assign imem_addr    = imem_req ? pc_value : 16'h0000;
    assign instr_valid  = (r_state == S_ISSUE);
    assign instr        = r_instr;
    assign halted       = (r_state == S_HALT);
    assign fetch_error  = r_fetch_error;
    assign epc          = r_epc;
    assign irq_ack      = w_take_irq;

    // PC controls are only meaningful in the exec_done cycle; zero elsewhere.
    assign pc_enable    = w_resolve;
    assign pc_increment = w_resolve && (exec_halt || w_seq);
    assign pc_load      = w_resolve && !exec_halt && (irq || exec_jump);
    assign pc_in        = (!w_resolve || exec_halt) ? 16'h0000 :
                          irq                       ? IRQ_VECTOR :
                          exec_jump                 ? exec_target : 16'h0000;
    assign pc_offset    = (w_resolve && !exec_halt && !irq && !exec_jump && exec_branch)
                          ? exec_offset : 16'h0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_tmo_cnt     <= '0;
            r_instr       <= 16'h0000;
            r_epc         <= 16'h0000;
            r_fetch_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_instr   <= imem_data;
                        r_tmo_cnt <= '0;
                        r_state   <= S_ISSUE;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_fetch_error <= 1'b1;
                        r_tmo_cnt     <= '0;
                        r_state       <= S_HALT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_CNT_ONE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        r_state <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    if (exec_done) begin
                        if (exec_halt) begin
                            r_state <= S_HALT;
                        end else begin
                            if (irq) begin
                                r_epc <= w_next_pc;
                            end
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (run) begin
                        r_fetch_error <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
